// File: rtl/key_match_table_pkg.sv
`default_nettype none
// ============================================================================
// key_match_table_pkg : shared pipeline constants (key extractor + match table)
// Rev 1.0
// ============================================================================
package key_match_table_pkg;

   // Key extractor constants
   localparam int C_PHV_LEN     = 1024;
   localparam int C_KEY_OFF_W   = 6;
   localparam int C_KEY_CONF_W  = 8;

   // Match table defaults
   localparam int C_KEY_LEN     = 896;
   localparam int C_MASK_LEN    = 896;
   localparam int C_ACT_LEN     = 64;
   localparam int C_ENTRY_NUM   = 16;
   localparam int C_IDX_W       = 4;

endpackage
`default_nettype wire

// File: rtl/match_prio_enc.sv
`default_nettype none
// ============================================================================
// match_prio_enc : combinational priority encoder, lowest set bit wins
// Rev 1.0
// ============================================================================
module match_prio_enc
   import key_match_table_pkg::*;
#(
   parameter int ENTRY_NUM = C_ENTRY_NUM,
   parameter int IDX_W     = C_IDX_W
)(
   input  logic [ENTRY_NUM-1:0] match_i,
   output logic                 hit_o,
   output logic [IDX_W-1:0]     idx_o
);

   always_comb begin
      hit_o = |match_i;
      idx_o = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (match_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/key_match_table.sv
`default_nettype none
// ============================================================================
// key_match_table : 3-stage masked key lookup against a configurable table
// Rev 1.0
// ============================================================================
module key_match_table
   import key_match_table_pkg::*;
#(
   parameter int KEY_LEN   = C_KEY_LEN,
   parameter int MASK_LEN  = C_MASK_LEN,
   parameter int ACT_LEN   = C_ACT_LEN,
   parameter int ENTRY_NUM = C_ENTRY_NUM,
   parameter int IDX_W     = C_IDX_W
)(
   input  logic                axis_clk,
   input  logic                aresetn,
   input  logic                key_valid,
   input  logic [KEY_LEN-1:0]  extract_key,
   input  logic                key_mask_valid,
   input  logic [MASK_LEN-1:0] key_mask,
   input  logic                cfg_wr_en,
   input  logic [IDX_W-1:0]    cfg_addr,
   input  logic                cfg_entry_vld,
   input  logic [KEY_LEN-1:0]  cfg_key,
   input  logic [ACT_LEN-1:0]  cfg_action,
   output logic                lookup_valid,
   output logic                lookup_hit,
   output logic [IDX_W-1:0]    lookup_index,
   output logic [ACT_LEN-1:0]  lookup_action
);

   logic [ENTRY_NUM-1:0] entry_vld_q;
   logic [KEY_LEN-1:0]   entry_key_q [ENTRY_NUM];
   logic [ACT_LEN-1:0]   entry_act_q [ENTRY_NUM];

   logic                 wr_pend_q;
   logic [IDX_W-1:0]     wr_addr_q;
   logic                 wr_vld_q;
   logic [KEY_LEN-1:0]   wr_key_q;
   logic [ACT_LEN-1:0]   wr_act_q;

   logic                 s1_vld_q;
   logic [KEY_LEN-1:0]   s1_key_q;
   logic [MASK_LEN-1:0]  s1_mask_q;
   logic [MASK_LEN-1:0]  s1_mask_d;

   logic                 s2_vld_q;
   logic [ENTRY_NUM-1:0] s2_match_q;
   logic [ENTRY_NUM-1:0] s2_match_d;
   logic [ACT_LEN-1:0]   s2_act_q [ENTRY_NUM];

   logic                 s3_hit_d;
   logic [IDX_W-1:0]     s3_idx_d;

   logic                 lookup_valid_q;
   logic                 lookup_hit_q;
   logic [IDX_W-1:0]     lookup_index_q;
   logic [ACT_LEN-1:0]   lookup_action_q;

   always_comb begin
      s1_mask_d = key_mask_valid ? key_mask : '1;
   end

   always_comb begin
      s2_match_d = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         s2_match_d[i] = entry_vld_q[i] &&
                         ((s1_key_q & s1_mask_q) == (entry_key_q[i] & s1_mask_q));
      end
   end

   match_prio_enc #(
      .ENTRY_NUM (ENTRY_NUM),
      .IDX_W     (IDX_W)
   ) u_prio_enc (
      .match_i (s2_match_q),
      .hit_o   (s3_hit_d),
      .idx_o   (s3_idx_d)
   );

   // Config writes land one edge late, so a lookup accepted on the write edge
   // still compares against the previous table contents.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_pend_q       <= 1'b0;
         entry_vld_q     <= '0;
         s1_vld_q        <= 1'b0;
         s2_vld_q        <= 1'b0;
         lookup_valid_q  <= 1'b0;
         lookup_hit_q    <= 1'b0;
         lookup_index_q  <= '0;
         lookup_action_q <= '0;
      end else begin
         wr_pend_q      <= cfg_wr_en;
         if (wr_pend_q) begin
            entry_vld_q[wr_addr_q] <= wr_vld_q;
         end
         s1_vld_q       <= key_valid;
         s2_vld_q       <= s1_vld_q;
         lookup_valid_q <= s2_vld_q;
         if (s2_vld_q) begin
            lookup_hit_q    <= s3_hit_d;
            lookup_index_q  <= s3_idx_d;
            lookup_action_q <= s3_hit_d ? s2_act_q[s3_idx_d] : '0;
         end
      end
   end

   always_ff @(posedge axis_clk) begin
      if (cfg_wr_en) begin
         wr_addr_q <= cfg_addr;
         wr_vld_q  <= cfg_entry_vld;
         wr_key_q  <= cfg_key;
         wr_act_q  <= cfg_action;
      end
      if (wr_pend_q) begin
         entry_key_q[wr_addr_q] <= wr_key_q;
         entry_act_q[wr_addr_q] <= wr_act_q;
      end
      if (key_valid) begin
         s1_key_q  <= extract_key;
         s1_mask_q <= s1_mask_d;
      end
      if (s1_vld_q) begin
         s2_match_q <= s2_match_d;
         s2_act_q   <= entry_act_q;
      end
   end

   assign lookup_valid  = lookup_valid_q;
   assign lookup_hit    = lookup_hit_q;
   assign lookup_index  = lookup_index_q;
   assign lookup_action = lookup_action_q;

endmodule
`default_nettype wire

// File: doc/key_match_table.md
KEY_MATCH_TABLE -- requirements
Module: key_match_table

Interface
REQ-001 SHALL have parameter KEY_LEN, default 896, lookup key width in bits.
REQ-002 SHALL have parameter MASK_LEN, default 896, lookup mask width; SHALL equal KEY_LEN.
REQ-003 SHALL have parameter ACT_LEN, default 64, action word width.
REQ-004 SHALL have parameter ENTRY_NUM, default 16, table depth, a power of two.
REQ-005 SHALL have parameter IDX_W, default 4, log2(ENTRY_NUM).
REQ-006 axis_clk  input  1  clock; all logic on rising edge.
REQ-007 aresetn  input  1  reset, asynchronous, active-low.
REQ-008 key_valid  input  1  lookup request strobe from key extractor.
REQ-009 extract_key  input  KEY_LEN  lookup key.
REQ-010 key_mask_valid  input  1  qualifies key_mask this cycle.
REQ-011 key_mask  input  MASK_LEN  care-bit mask; 1 = compare bit.
REQ-012 cfg_wr_en  input  1  table entry write strobe.
REQ-013 cfg_addr  input  IDX_W  entry index to write.
REQ-014 cfg_entry_vld  input  1  valid flag stored with the entry.
REQ-015 cfg_key  input  KEY_LEN  entry key.
REQ-016 cfg_action  input  ACT_LEN  entry action.
REQ-017 lookup_valid  output  1  result strobe, one cycle per request.
REQ-018 lookup_hit  output  1  at least one valid entry matched.
REQ-019 lookup_index  output  IDX_W  winning entry index; 0 on miss.
REQ-020 lookup_action  output  ACT_LEN  winning entry action; 0 on miss.

Function
REQ-021 SHALL accept one request per cycle when key_valid=1; no backpressure.
REQ-022 Stage 1 (S1) SHALL register key and effective mask: key_mask if key_mask_valid=1, else all-ones (exact match).
REQ-023 Stage 2 (S2) SHALL compute per entry match[i] = entry_vld[i] AND ((S1 key AND mask) == (entry_key[i] AND mask)), registered.
REQ-024 Stage 3 (S3) SHALL priority-encode match, lowest index wins, registering lookup_hit, lookup_index, lookup_action.
REQ-025 lookup_valid SHALL assert exactly 3 cycles after the key_valid cycle; back-to-back requests yield back-to-back results in order.
REQ-026 key_mask_valid=1 with key_valid=0 SHALL be ignored.
REQ-027 All-zero effective mask SHALL match every valid entry.
REQ-028 On miss, lookup_hit=0, lookup_index=0, lookup_action=0.
REQ-029 Output data SHALL hold its last value while lookup_valid=0.
REQ-030 cfg write SHALL update entry cfg_addr on the clock edge where cfg_wr_en=1; cfg_entry_vld=0 invalidates the entry.
REQ-031 S2 compare SHALL use table contents before a same-edge write (write visible to S2 from the following cycle).
REQ-032 S3 action read SHALL use the action captured with the match vector in S2, so a write between S2 and S3 cannot mix entries.
REQ-033 Width: index and action SHALL be exact-width, no truncation; cfg_addr covers all ENTRY_NUM entries.

Reset
REQ-034 On aresetn=0, all outputs SHALL go to 0 immediately and pipeline valid bits SHALL clear.
REQ-035 Reset SHALL clear all entry valid flags; entry key/action storage need not be reset.
REQ-036 Requests in flight at reset SHALL be discarded; no lookup_valid for them after release.
REQ-037 First request accepted on the first rising edge with aresetn=1.

Structure
REQ-038 KEY_LEN, MASK_LEN, ACT_LEN, ENTRY_NUM, IDX_W defaults SHALL live in the shared pipeline package with the key extractor's constants.
REQ-039 Priority encoder SHALL be one sub-module, match_prio_enc (ENTRY_NUM-bit vector in, hit and IDX_W index out, combinational).

Verification
REQ-040 Write entry 3 key=0xAB.., vld=1, action=0x11; lookup same key, key_mask_valid=0 -> lookup_valid at +3, hit=1, index=3, action=0x11.
REQ-041 Entries 2 and 5 both match under mask low-16-bits-only -> index=2.
REQ-042 Lookup key matching no entry -> hit=0, index=0, action=0.
REQ-043 Write entry 3 vld=0 on same edge as key_valid for its key -> hit=1 (old contents); repeat next cycle -> hit=0.
REQ-044 Four back-to-back keys -> four consecutive lookup_valid pulses, correct order.
REQ-045 aresetn low with two requests in flight -> outputs 0 immediately, no lookup_valid after release, all entries miss.
